// File: rtl/breakout_pkg.sv
// Shared breakout definitions: FSM state codes, default
// game parameters and the saturating BCD score increment.
package breakout_pkg;

    typedef enum logic [2:0] {
        ST_NEWGAME = 3'd0,
        ST_PLAY    = 3'd1,
        ST_NEWBALL = 3'd2,
        ST_OVER    = 3'd3,
        ST_WIN     = 3'd4
    } state_t;

    localparam int LIVES_INIT_DEF  = 3;
    localparam int NUM_BRICKS_DEF  = 6;
    localparam int DELAY_TICKS_DEF = 120;

    // Two-digit BCD +1, sticking at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s == 8'h99)
            r = s;
        else if (s[3:0] == 4'd9)
            r = {s[7:4] + 4'd1, 4'd0};
        else
            r = {s[7:4], s[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/game_timer.sv
// Frame-tick pause timer: load to DELAY_TICKS, count down
// on refresh ticks, park at zero.
module game_timer
    import breakout_pkg::*;
#(
    parameter int DELAY_TICKS = DELAY_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic done
);

    logic [6:0] count;

    // Load wins over a coincident tick; zero is sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= 7'd0;
        else if (load)
            count <= 7'(DELAY_TICKS);
        else if (tick && count != 7'd0)
            count <= count - 7'd1;
    end

    assign done = (count == 7'd0);

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: state FSM, BCD score, lives and
// brick bookkeeping, all outputs registered.
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int LIVES_INIT  = LIVES_INIT_DEF,
    parameter int NUM_BRICKS  = NUM_BRICKS_DEF,
    parameter int DELAY_TICKS = DELAY_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refr_tick,
    input  logic [4:0] btn,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [2:0] game_state,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [1:0] lives,
    output logic [5:0] bricks_left
);

    localparam logic [1:0] LIVES0  = 2'(LIVES_INIT);
    localparam logic [5:0] BRICKS0 = 6'(NUM_BRICKS);

    state_t     state_q, state_n;
    logic [7:0] score_q, score_n;
    logic [1:0] lives_q, lives_n;
    logic [5:0] bricks_q, bricks_n;
    logic       still_q;
    logic       load;
    logic       done;

    game_timer #(
        .DELAY_TICKS(DELAY_TICKS)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .tick (refr_tick),
        .done (done)
    );

    // Next state and counter updates; WIN beats OVER/NEWBALL.
    always_comb begin
        state_n  = state_q;
        score_n  = score_q;
        lives_n  = lives_q;
        bricks_n = bricks_q;
        load     = 1'b0;
        case (state_q)
            ST_NEWGAME: begin
                if (|btn) begin
                    state_n  = ST_PLAY;
                    score_n  = 8'h00;
                    lives_n  = LIVES0;
                    bricks_n = BRICKS0;
                end
            end
            ST_PLAY: begin
                if (hit) begin
                    score_n = bcd_inc(score_q);
                    if (bricks_q != 6'd0)
                        bricks_n = bricks_q - 6'd1;
                end
                if (miss && lives_q != 2'd0)
                    lives_n = lives_q - 2'd1;
                if (hit && bricks_q == 6'd1) begin
                    state_n = ST_WIN;
                    load    = 1'b1;
                end else if (miss) begin
                    state_n = (lives_q <= 2'd1) ? ST_OVER
                                                : ST_NEWBALL;
                    load    = 1'b1;
                end
            end
            ST_NEWBALL: begin
                if (done && |btn)
                    state_n = ST_PLAY;
            end
            ST_OVER, ST_WIN: begin
                if (done)
                    state_n = ST_NEWGAME;
            end
            default: state_n = ST_NEWGAME;
        endcase
    end

    // State, game counters and the freeze flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_NEWGAME;
            score_q  <= 8'h00;
            lives_q  <= LIVES0;
            bricks_q <= BRICKS0;
            still_q  <= 1'b1;
        end else begin
            state_q  <= state_n;
            score_q  <= score_n;
            lives_q  <= lives_n;
            bricks_q <= bricks_n;
            still_q  <= (state_n != ST_PLAY);
        end
    end

    assign game_state  = state_q;
    assign gra_still   = still_q;
    assign score_d1    = score_q[7:4];
    assign score_d0    = score_q[3:0];
    assign lives       = lives_q;
    assign bricks_left = bricks_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Self-checking bench for breakout_game_ctrl: vector table,
// directed corner sequences and a random run against a model.
module tb_breakout_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       refr_tick = 1'b0;
    logic [4:0] btn = 5'd0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;

    logic       still, still63;
    logic [2:0] gst, gst63;
    logic [3:0] d1, d0, d1_63, d0_63;
    logic [1:0] lv, lv63;
    logic [5:0] bl, bl63;

    int n_chk = 0;
    int n_pass = 0;

    breakout_game_ctrl dut (
        .clk(clk), .reset(reset), .refr_tick(refr_tick),
        .btn(btn), .hit(hit), .miss(miss),
        .gra_still(still), .game_state(gst),
        .score_d1(d1), .score_d0(d0),
        .lives(lv), .bricks_left(bl)
    );

    breakout_game_ctrl #(.NUM_BRICKS(63)) dut63 (
        .clk(clk), .reset(reset), .refr_tick(refr_tick),
        .btn(btn), .hit(hit), .miss(miss),
        .gra_still(still63), .game_state(gst63),
        .score_d1(d1_63), .score_d0(d0_63),
        .lives(lv63), .bricks_left(bl63)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  b;
        logic        h;
        logic        m;
        logic        t;
        logic [19:0] exp;
    } vec_t;

    vec_t tv[8];

    function automatic logic [19:0] pk(int st, int score,
                                       int lives, int bricks);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(score / 10);
        u = 4'(score % 10);
        return {3'(st), (st != 1), t, u, 2'(lives), 6'(bricks)};
    endfunction

    function automatic logic [19:0] obs();
        return {gst, still, d1, d0, lv, bl};
    endfunction

    function automatic logic [19:0] obs63();
        return {gst63, still63, d1_63, d0_63, lv63, bl63};
    endfunction

    task automatic check(string name, logic [19:0] act,
                         logic [19:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (st,still,bcd,lives,bricks)",
                     name, act, exp);
    endtask

    task automatic cyc(logic [4:0] b, logic h, logic m, logic t);
        @(negedge clk);
        btn = b; hit = h; miss = m; refr_tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic pause(int n);
        for (int i = 0; i < n; i++)
            cyc(5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn = 5'd0; hit = 0; miss = 0; refr_tick = 0;
        #1 reset = 1'b1;
        #1;
        check("reset_async", obs(), pk(0, 0, 3, 6));
        check("reset_async63", obs63(), pk(0, 0, 3, 63));
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model state.
    int m_mode, m_score, m_lives, m_bricks, m_pause;

    task automatic model_reset();
        m_mode = 0; m_score = 0; m_lives = 3;
        m_bricks = 6; m_pause = 0;
    endtask

    task automatic model_step(logic [4:0] b, logic h,
                              logic m, logic t);
        int pz;
        bit ld;
        pz = m_pause;
        ld = 0;
        case (m_mode)
            0: if (b != 0) begin
                m_mode = 1; m_score = 0;
                m_lives = 3; m_bricks = 6;
            end
            1: begin
                if (h) begin
                    m_score = (m_score < 99) ? m_score + 1 : 99;
                    m_bricks = m_bricks - 1;
                end
                if (m) m_lives = m_lives - 1;
                if (h && m_bricks == 0) begin
                    m_mode = 4; ld = 1;
                end else if (m) begin
                    m_mode = (m_lives == 0) ? 3 : 2; ld = 1;
                end
            end
            2: if (pz == 0 && b != 0) m_mode = 1;
            default: if (pz == 0) m_mode = 0;
        endcase
        if (ld) m_pause = 120;
        else if (t && m_pause > 0) m_pause = m_pause - 1;
    endtask

    initial begin
        tv[0] = '{5'h01, 0, 0, 0, pk(1, 0, 3, 6)};
        tv[1] = '{5'h00, 1, 0, 0, pk(1, 1, 3, 5)};
        tv[2] = '{5'h00, 1, 0, 1, pk(1, 2, 3, 4)};
        tv[3] = '{5'h00, 0, 1, 0, pk(2, 2, 2, 4)};
        tv[4] = '{5'h00, 1, 0, 0, pk(2, 2, 2, 4)};
        tv[5] = '{5'h10, 0, 0, 0, pk(2, 2, 2, 4)};
        tv[6] = '{5'h00, 0, 1, 0, pk(2, 2, 2, 4)};
        tv[7] = '{5'h00, 0, 0, 1, pk(2, 2, 2, 4)};

        do_reset();
        check("reset_hold", obs(), pk(0, 0, 3, 6));

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            cyc(tv[i].b, tv[i].h, tv[i].m, tv[i].t);
            check($sformatf("vec%0d", i), obs(), tv[i].exp);
        end
        pause(118);
        cyc(5'h02, 0, 0, 0);
        check("nb_early_btn", obs(), pk(2, 2, 2, 4));
        pause(1);
        cyc(5'h02, 0, 0, 0);
        check("nb_resume", obs(), pk(1, 2, 2, 4));

        // Six hits to WIN, pause back to NEWGAME
        do_reset();
        cyc(5'h01, 0, 0, 0);
        check("start", obs(), pk(1, 0, 3, 6));
        for (int i = 0; i < 6; i++) cyc(5'h00, 1, 0, 0);
        check("win", obs(), pk(4, 6, 3, 0));
        pause(119);
        cyc(5'h00, 0, 0, 0);
        check("win_hold", obs(), pk(4, 6, 3, 0));
        pause(1);
        check("win_done", obs(), pk(4, 6, 3, 0));
        cyc(5'h00, 0, 0, 0);
        check("win_newgame", obs(), pk(0, 6, 3, 0));

        // Three misses to OVER
        cyc(5'h01, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(5'h00, 0, 1, 0);
            check($sformatf("miss%0d", k), obs(),
                  pk(k == 2 ? 3 : 2, 0, 2 - k, 6));
            pause(120);
            cyc(5'h01, 0, 0, 0);
        end
        check("over_newgame", obs(), pk(0, 0, 0, 6));

        // NEWBALL with button held from entry
        do_reset();
        cyc(5'h01, 0, 0, 0);
        cyc(5'h01, 0, 1, 0);
        begin
            bit held_ok = 1;
            for (int i = 0; i < 120; i++) begin
                cyc(5'h01, 0, 0, 1);
                if (gst !== 3'd2) held_ok = 0;
            end
            check("nb_held", {19'd0, held_ok}, 20'd1);
        end
        cyc(5'h01, 0, 0, 0);
        check("nb_held_play", obs(), pk(1, 0, 2, 6));

        // Last brick and last ball in the same clk
        do_reset();
        cyc(5'h01, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            cyc(5'h00, 0, 1, 0);
            pause(120);
            cyc(5'h01, 0, 0, 0);
        end
        for (int i = 0; i < 5; i++) cyc(5'h00, 1, 0, 0);
        check("pre_both", obs(), pk(1, 5, 1, 1));
        cyc(5'h00, 1, 1, 0);
        check("hit_miss_win", obs(), pk(4, 6, 0, 0));

        // BCD carry on the 63-brick instance, then async reset
        do_reset();
        @(negedge clk);
        btn = 5'h01;
        #1;
        check("no_change_before_edge", obs63(), pk(0, 0, 3, 63));
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) cyc(5'h00, 1, 0, 0);
        check("score09", obs63(), pk(1, 9, 3, 54));
        cyc(5'h00, 1, 0, 0);
        check("bcd_carry", obs63(), pk(1, 10, 3, 53));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid_reset63", obs63(), pk(0, 0, 3, 63));
        @(negedge clk);
        reset = 1'b0;
        cyc(5'h00, 0, 0, 1);
        check("post_reset63", obs63(), pk(0, 0, 3, 63));

        // Random run against the model
        do_reset();
        model_reset();
        begin
            int errs = 0;
            for (int i = 0; i < 6000; i++) begin
                logic [4:0] b;
                logic h, m, t;
                b = ($urandom_range(99, 0) < 15)
                    ? 5'($urandom_range(31, 1)) : 5'd0;
                h = ($urandom_range(99, 0) < 12);
                m = ($urandom_range(99, 0) < 4);
                t = ($urandom_range(99, 0) < 45);
                if ($urandom_range(999, 0) == 0) begin
                    do_reset();
                    model_reset();
                end else begin
                    cyc(b, h, m, t);
                    model_step(b, h, m, t);
                    if (errs < 10) begin
                        check($sformatf("rand%0d", i), obs(),
                              pk(m_mode, m_score, m_lives, m_bricks));
                        if (obs() !== pk(m_mode, m_score,
                                         m_lives, m_bricks))
                            errs++;
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
